// File: rtl/bram_stream_pkg.sv
// Shared types and constants for the BRAM read-stream engine.
//   state_t   : engine FSM states
//   BUF_DEPTH : output buffer depth in beats
//   BUF_CNTW  : width of an occupancy count 0..BUF_DEPTH
package bram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam int unsigned BUF_DEPTH = 4;
    localparam int unsigned BUF_CNTW  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/bram_read_stream_if.sv
// Valid/ready output stream of the BRAM read engine.
//   out_data  : beat payload
//   out_valid : beat available
//   out_ready : consumer accepts
//   out_last  : final beat of the burst
// master = engine side, slave = consumer side.
interface bram_read_stream_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/fifo_sync_small.sv
// Small single-clock FIFO with registered storage and occupancy count.
//   clk, rst_n : clock, async active-low reset (storage cleared)
//   push, din  : write one entry (caller guarantees not full)
//   pop        : remove head entry (ignored when empty)
//   dout       : head entry
//   count      : current occupancy 0..DEPTH
module fifo_sync_small #(
    parameter  int unsigned WIDTH = 9,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNTW-1:0]  count
);

    localparam int unsigned PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count_q;
    logic             do_pop;

    // Pointer advance with explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    assign do_pop = pop && (count_q != '0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !do_pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (!push && do_pop) begin
                count_q <= count_q - CNTW'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/bram_read_stream.sv
// Sequential read engine for a BRAM read port with a valid/ready output.
//   clk, rst_n     : clock (shared with RAM read port), async active-low reset
//   start          : burst request, sampled only while idle
//   base_addr, len : burst start address and word count (0..DEPTH)
//   busy, done     : burst in progress / one-cycle completion pulse
//   addr_read      : registered RAM read address
//   bram_data      : RAM read data, one cycle after addr_read
//   strm           : output stream (master side)
module bram_read_stream
    import bram_stream_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned ADDRW = $clog2(DEPTH),
    localparam int unsigned LENW  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDRW-1:0]  base_addr,
    input  logic [LENW-1:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDRW-1:0]  addr_read,
    input  logic [WIDTH-1:0]  bram_data,
    bram_read_stream_if.master strm
);

    localparam int unsigned PW = BUF_CNTW + 1;

    state_t             state_q, state_d;
    logic               busy_d, done_d;
    logic [ADDRW-1:0]   addr_d;
    logic [LENW-1:0]    remain_q, remain_d;
    logic               issue, issue_last;
    logic               rd_v1, rd_v2, last_v1, last_v2;
    logic [BUF_CNTW-1:0] buf_count;
    logic [WIDTH:0]     head;
    logic               pop;
    logic [PW-1:0]      pend;
    logic               can_issue;

    function automatic logic [ADDRW-1:0] next_addr(input logic [ADDRW-1:0] a);
        return (a == ADDRW'(DEPTH - 1)) ? '0 : a + ADDRW'(1);
    endfunction

    assign strm.out_valid = (buf_count != '0);
    assign strm.out_data  = head[WIDTH-1:0];
    assign strm.out_last  = head[WIDTH];
    assign pop            = strm.out_valid && strm.out_ready;

    // Occupancy plus in-flight reads after this edge, before any new issue.
    assign pend      = PW'(buf_count) + PW'(rd_v1) + PW'(rd_v2) - PW'(pop);
    assign can_issue = (pend < PW'(BUF_DEPTH));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy;
        done_d     = 1'b0;
        addr_d     = addr_read;
        remain_d   = remain_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        // Pipeline is empty while idle, so the first read goes out with the start.
                        issue      = 1'b1;
                        issue_last = (len == LENW'(1));
                        addr_d     = base_addr;
                        remain_d   = len - LENW'(1);
                        state_d    = (len == LENW'(1)) ? DRAIN : READ;
                    end
                end
            end
            READ: begin
                if (can_issue) begin
                    issue      = 1'b1;
                    issue_last = (remain_q == LENW'(1));
                    addr_d     = next_addr(addr_read);
                    remain_d   = remain_q - LENW'(1);
                    if (remain_q == LENW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((buf_count == '0) && !rd_v1 && !rd_v2) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, outputs and the two-stage read-latency tracker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_read <= '0;
            remain_q  <= '0;
            rd_v1     <= 1'b0;
            rd_v2     <= 1'b0;
            last_v1   <= 1'b0;
            last_v2   <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy      <= busy_d;
            done      <= done_d;
            addr_read <= addr_d;
            remain_q  <= remain_d;
            rd_v1     <= issue;
            rd_v2     <= rd_v1;
            last_v1   <= issue_last;
            last_v2   <= last_v1;
        end
    end

    // Output buffer; capture happens the cycle bram_data holds the read word.
    fifo_sync_small #(
        .WIDTH (WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rd_v2),
        .pop   (pop),
        .din   ({last_v2, bram_data}),
        .dout  (head),
        .count (buf_count)
    );

endmodule

// File: tb/tb_bram_read_stream.sv
// Self-checking bench for bram_read_stream with a RAM model and a queue-based reference.
module tb_bram_read_stream;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] len;
    logic       busy, done;
    logic [7:0] addr_read;
    logic [7:0] bram_data;

    bram_read_stream_if #(.WIDTH(8)) s ();

    bram_read_stream #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .addr_read (addr_read),
        .bram_data (bram_data),
        .strm      (s)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [DEPTH];
    always @(posedge clk) bram_data <= mem[addr_read];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Burst descriptor written by the stimulus, consumed by the monitor.
    int    burst_id = 0;
    int    exp_base = 0;
    int    exp_len = 0;
    int    done0 = 0;

    // Monitor-owned state.
    beat_t exp_q[$];
    int    seen_id = 0;
    int    issued = 0;
    int    popped = 0;
    int    nbeats = 0;
    int    cyc = 0;
    int    first_cyc = 0;
    int    last_cyc = 0;
    int    done_cnt = 0;
    logic  first_rd = 1'b0;
    logic  hold_pending = 1'b0;
    logic  prev_done = 1'b0;
    logic [8:0] held = '0;
    logic [7:0] prev_addr = '0;

    always @(negedge clk) begin
        cyc++;
        if (burst_id != seen_id) begin
            seen_id = burst_id;
            exp_q.delete();
            for (int i = 0; i < exp_len; i++) begin
                beat_t b;
                b.data = mem[(exp_base + i) % DEPTH];
                b.last = (i == exp_len - 1);
                exp_q.push_back(b);
            end
            issued   = 0;
            popped   = 0;
            nbeats   = 0;
            first_rd = (exp_len != 0);
        end
        if (rst_n) begin
            // Reads issued are visible as address steps; beats out of the buffer are pops.
            if (busy && first_rd) begin
                chk("first_addr", 32'(addr_read), 32'(exp_base));
                issued    = 1;
                prev_addr = addr_read;
                first_rd  = 1'b0;
            end else if (busy && exp_len != 0 && addr_read != prev_addr) begin
                chk("addr_step", 32'(addr_read), 32'((int'(prev_addr) + 1) % DEPTH));
                issued++;
                chk("issued_le_len", 32'(issued <= exp_len), 32'(1));
                prev_addr = addr_read;
            end
            if (busy && exp_len != 0 && issued != 0)
                chk("outstanding_le4", 32'((issued - popped) <= 4), 32'(1));
            if (hold_pending) begin
                chk("stall_valid", 32'(s.out_valid), 32'(1));
                chk("stall_hold", 32'({s.out_last, s.out_data}), 32'(held));
            end
            if (s.out_valid)
                chk("valid_expected", 32'(exp_q.size() != 0), 32'(1));
            if (s.out_valid && s.out_ready && exp_q.size() != 0) begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat", 32'({s.out_last, s.out_data}), 32'(e));
                if (nbeats == 0) first_cyc = cyc;
                last_cyc = cyc;
                nbeats++;
                popped++;
            end
            hold_pending = s.out_valid && !s.out_ready;
            held = {s.out_last, s.out_data};
            if (prev_done) chk("busy_after_done", 32'(busy), 32'(0));
            if (done) begin
                chk("done_single", 32'(prev_done), 32'(0));
                done_cnt++;
            end
            prev_done = done;
        end else begin
            hold_pending = 1'b0;
            prev_done    = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_burst(input int b, input int l);
        exp_base  = b;
        exp_len   = l;
        burst_id++;
        done0     = done_cnt;
        start     = 1'b1;
        base_addr = 8'(b);
        len       = 9'(l);
        tick();
        start     = 1'b0;
    endtask

    // mode 0: ready=1, 1: random ready, 2: stall 10 cycles after first valid, then random.
    task automatic finish_burst(input int mode, input int max_cyc);
        int  stall;
        logic got;
        stall = 0;
        got = 1'b0;
        for (int i = 0; i < max_cyc && !got; i++) begin
            case (mode)
                0: s.out_ready = 1'b1;
                1: s.out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if ((stall > 0 || s.out_valid) && stall < 10) begin
                        s.out_ready = 1'b0;
                        stall++;
                    end else begin
                        s.out_ready = 1'($urandom_range(0, 1));
                    end
                end
            endcase
            @(negedge clk);
            #1;
            if (done_cnt != done0) got = 1'b1;
            tick();
        end
        chk("done_seen", 32'(got), 32'(1));
        chk("done_count", 32'(done_cnt - done0), 32'(1));
        chk("all_beats", 32'(exp_q.size()), 32'(0));
        chk("beat_count", 32'(nbeats), 32'(exp_len));
        if (mode == 0 && exp_len > 0)
            chk("no_bubbles", 32'(last_cyc - first_cyc), 32'(exp_len - 1));
        s.out_ready = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        s.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_valid", 32'(s.out_valid), 32'(0));
        chk("rst_last", 32'(s.out_last), 32'(0));
        chk("rst_addr", 32'(addr_read), 32'(0));
        chk("rst_data", 32'(s.out_data), 32'(0));
        #1;
        rst_n = 1'b1;
        tick();
        tick();

        // Basic burst with latency checks.
        begin_burst(32'h10, 4);
        @(negedge clk);
        chk("lat_busy", 32'(busy), 32'(1));
        chk("lat_valid_s0", 32'(s.out_valid), 32'(0));
        chk("lat_addr", 32'(addr_read), 32'h10);
        tick();
        @(negedge clk);
        chk("lat_valid_s1", 32'(s.out_valid), 32'(0));
        tick();
        @(negedge clk);
        chk("lat_valid_s2", 32'(s.out_valid), 32'(1));
        chk("lat_data_s2", 32'(s.out_data), 32'h10);
        finish_burst(0, 50);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        tick();

        // Address wrap.
        begin_burst(32'hFE, 4);
        finish_burst(0, 50);

        // Backpressure.
        begin_burst(0, 16);
        finish_burst(2, 300);

        // Zero length.
        begin_burst(32'h33, 0);
        finish_burst(0, 20);

        // Full length across the wrap.
        begin_burst(32'h80, 256);
        finish_burst(0, 400);

        // Start while busy is ignored.
        begin_burst(32'h20, 8);
        tick();
        tick();
        start = 1'b1;
        base_addr = 8'h90;
        len = 9'd5;
        tick();
        start = 1'b0;
        finish_burst(1, 200);
        repeat (10) tick();
        chk("busy_start_one_done", 32'(done_cnt - done0), 32'(1));

        // Start during done is ignored; one cycle later it is accepted.
        begin_burst(32'h05, 3);
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                #1;
                if (done_cnt != done0) got = 1'b1;
                else tick();
            end
            chk("chain_done_seen", 32'(got), 32'(1));
        end
        start = 1'b1;
        base_addr = 8'hA0;
        len = 9'd2;
        tick();
        chk("chain_first_empty", 32'(exp_q.size()), 32'(0));
        exp_base = 32'h50;
        exp_len = 3;
        burst_id++;
        done0 = done_cnt;
        base_addr = 8'h50;
        len = 9'd3;
        tick();
        start = 1'b0;
        finish_burst(0, 50);

        // Randomised bursts with random backpressure.
        for (int k = 0; k < 3; k++) begin
            begin_burst(int'($urandom_range(0, 255)), int'($urandom_range(1, 40)));
            finish_burst(1, 400);
        end

        // Mid-burst reset.
        begin_burst(32'h60, 12);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (popped >= 3) break;
            tick();
        end
        chk("mid_three_beats", 32'(popped), 32'(3));
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'(0));
        chk("mid_rst_done", 32'(done), 32'(0));
        chk("mid_rst_valid", 32'(s.out_valid), 32'(0));
        chk("mid_rst_last", 32'(s.out_last), 32'(0));
        chk("mid_rst_addr", 32'(addr_read), 32'(0));
        chk("mid_rst_data", 32'(s.out_data), 32'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_done", 32'(done_cnt - done0), 32'(0));
        begin_burst(32'h40, 2);
        finish_burst(0, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bram_read_stream.md
Name: bram_read_stream

Overview:
- Sequential read engine for a simple dual-port block RAM's read port.
- On a start pulse it walks a programmed address range and drives the RAM read address.
- It absorbs the RAM's one-cycle registered read latency and presents the words as a valid/ready stream with an end-of-burst marker.
- It sits directly downstream of the RAM in line-buffer and framebuffer read paths. It shares the RAM read clock.

Parameters:
- WIDTH, 8, data word width; must match the RAM WIDTH.
- DEPTH, 256, RAM depth in words; any value ≥2, power of two not required.
- ADDRW, $clog2(DEPTH), address width (localparam).
- LENW, $clog2(DEPTH+1), burst length width; allows len=DEPTH (localparam).

Ports:
- clk  input  1  system clock; also drives the RAM read clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  1-cycle request; sampled only when busy=0.
- base_addr  input  ADDRW  first address; sampled with start.
- len  input  LENW  number of words; sampled with start; 0..DEPTH.
- busy  output  1  high while a burst is in progress.
- done  output  1  1-cycle pulse when the burst completes.
- addr_read  output  ADDRW  to RAM addr_read; registered.
- bram_data  input  WIDTH  from RAM data_out; valid one clk after addr_read is sampled.
- out_data  output  WIDTH  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready from the consumer.
- out_last  output  1  high with the final beat of a burst.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - busy, done, out_valid and out_last go to 0.
  - addr_read and out_data go to 0.
  - State goes to IDLE; the buffer is emptied and in-flight tracking is cleared.
  - Reset mid-burst abandons the burst silently; no done pulse.
- State IDLE:
  - start=1 with len≠0: latch base and len, go to READ, busy=1 after the edge.
  - start=1 with len=0: go to FINISH; no beats are produced.
  - start while busy=1 is ignored entirely.
- State READ:
  - Each cycle a read is permitted, addr_read advances to the next address.
  - The address wraps from DEPTH-1 to 0, explicitly, not by truncation.
  - When len reads have been issued, go to DRAIN.
- State DRAIN: wait until the buffer is empty and no reads are in flight, then go to FINISH.
- State FINISH: done=1 for exactly one cycle, busy=0 after that edge, return to IDLE.
  - A start in the cycle done is high is ignored.
  - A start one cycle later is accepted.
- Read pipeline:
  - A read issued on edge N (addr_read valid after N) lands in bram_data after N+1.
  - It is captured into the output buffer on edge N+2.
- Latency: with start sampled on edge S and out_ready=1, out_valid first rises after edge S+2.
- Output buffer:
  - 4-entry FIFO.
  - Invariant: buffer occupancy plus reads in flight (issued, not yet captured) ≤ 4 at all times.
  - A new read is issued only if that invariant holds including the current-cycle pop.
  - No word is ever dropped or duplicated.
- Throughput: with out_ready held at 1, one beat per clk sustained, no bubbles after the first beat.
- Stream rules:
  - A beat transfers when out_valid & out_ready on a rising edge.
  - While out_valid=1 & out_ready=0, out_data and out_last hold stable and out_valid is not withdrawn.
  - out_valid never depends combinationally on out_ready.
- out_last is 1 only on the len-th beat of the burst.
- Beat order equals address order, including across the wrap.

Decomposition:
- Shared package bram_stream_pkg:
  - state enum (IDLE, READ, DRAIN, FINISH).
  - Buffer depth constant BUF_DEPTH=4.
- One sub-module: fifo_sync_small.
  - Parameterised width and depth; carries {last, data}.
  - Provides push/pop and count outputs.
  - Same clk and rst_n.

Test Plan:
- Burst with out_ready held at 1:
  - Stimulus: mem[i]=i, base=0x10, len=4, out_ready=1, start on edge S.
  - Response: out_valid high from after S+2 for 4 consecutive cycles with data 10,11,12,13.
  - out_last on 13; done one cycle after the last handshake; busy then 0.
- Address wrap: DEPTH=256, base=0xFE, len=4 → data FE,FF,00,01 in that order; addr_read never exceeds 0xFF.
- Backpressure:
  - Stimulus: base=0, len=16, out_ready held low 10 cycles after the first valid, then random toggling.
  - Response: all 16 words delivered in order exactly once.
  - Data/last stable while stalled; outstanding (buffer + in flight) never exceeds 4.
- Zero and full length:
  - len=0 → done pulse, out_valid never asserted.
  - len=256, base=0x80 → 256 beats, out_last on mem[0x7F].
- Start while busy: a second start mid-burst with other base/len → ignored; only the first burst's beats and one done.
- Mid-burst reset: rst_n low after 3 beats → all outputs 0 immediately, no done. After release, a new burst base=0x40 len=2 → 40,41 normally.
